// File: rtl/bpc_block_seq.sv
// bpc_block_seq
//   Sequences words from an upstream source into fixed-size BPC blocks for
//   the downstream DBP/DBX encoder. Normal traffic is passed straight
//   through. On a flush request, the current partial block is completed with
//   zero pad words. The sequencer then waits for the encoder to go idle and
//   sends the encoder a single-cycle flush pulse.
//
// Parameters
//   BLOCK_SIZE  words per BPC block (power of two, >= 2); ebpc_pkg default 8
//   DATA_W      word width; ebpc_pkg default 8
//
// Ports
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   data_i      upstream word (signed; carried opaquely)
//   vld_i       upstream valid
//   rdy_o       upstream ready
//   flush_i     flush request, single-cycle pulse
//   data_o      word to encoder
//   vld_o       encoder-side valid
//   rdy_i       encoder ready
//   flush_o     flush to encoder, one-cycle pulse
//   enc_idle_i  encoder holds no partial block
//   idle_o      sequencer and encoder both empty
//   pad_cnt_o   saturating count of pad words inserted since reset
module bpc_block_seq #(
    parameter int unsigned BLOCK_SIZE = 8,
    parameter int unsigned DATA_W     = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] data_i,
    input  logic              vld_i,
    output logic              rdy_o,
    input  logic              flush_i,
    output logic [DATA_W-1:0] data_o,
    output logic              vld_o,
    input  logic              rdy_i,
    output logic              flush_o,
    input  logic              enc_idle_i,
    output logic              idle_o,
    output logic [15:0]       pad_cnt_o
);

    localparam int unsigned POS_W = $clog2(BLOCK_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        PASS,
        PAD,
        DRAIN,
        FLUSH
    } state_e;

    state_e            state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [15:0]       pad_cnt_q, pad_cnt_d;
    logic              hs;

    // Datapath muxing. vld_o is chosen by state only, never by rdy_i.
    always_comb begin
        data_o = data_i;
        vld_o  = vld_i;
        rdy_o  = rdy_i;
        unique case (state_q)
            PAD: begin
                data_o = '0;
                vld_o  = 1'b1;
                rdy_o  = 1'b0;
            end
            DRAIN, FLUSH: begin
                data_o = '0;
                vld_o  = 1'b0;
                rdy_o  = 1'b0;
            end
            default: ;
        endcase
    end

    assign hs        = vld_o & rdy_i;
    assign flush_o   = (state_q == FLUSH);
    assign idle_o    = (state_q == IDLE) && (pos_q == '0) && enc_idle_i;
    assign pad_cnt_o = pad_cnt_q;

    always_comb begin
        // BLOCK_SIZE is a power of two, so the natural wrap of pos is the
        // block boundary.
        pos_d     = hs ? pos_q + 1'b1 : pos_q;
        state_d   = state_q;
        pad_cnt_d = pad_cnt_q;
        unique case (state_q)
            IDLE, PASS: begin
                // A word accepted alongside the flush counts before the pad
                // decision, hence the test on pos_d rather than pos_q.
                if (flush_i) begin
                    state_d = (pos_d != '0) ? PAD : DRAIN;
                end else if (hs) begin
                    state_d = (pos_d == '0) ? IDLE : PASS;
                end
            end
            PAD: begin
                if (hs) begin
                    if (pad_cnt_q != 16'hFFFF) begin
                        pad_cnt_d = pad_cnt_q + 16'd1;
                    end
                    if (pos_d == '0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (enc_idle_i) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pos_q     <= '0;
            pad_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            pad_cnt_q <= pad_cnt_d;
        end
    end

endmodule
